// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared timing constants and helpers for the VGA display timing
//            generator. Defaults describe 640x480@60 with a 25 MHz pixel rate.
//            Helper functions derive totals and sync windows from the
//            active/porch/sync widths so every user computes them identically.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Coordinate width; all raster arithmetic is unsigned at this width.
    localparam int c_COORD_W = 12;

    typedef logic [c_COORD_W-1:0] coord_t;

    // Raw/delayed sync pair carried through the sync delay line.
    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    // 640x480@60 defaults.
    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    // Total positions along one axis (columns per line or lines per frame).
    function automatic coord_t f_total(input int active, input int fp,
                                       input int sync, input int bp);
        return coord_t'(active + fp + sync + bp);
    endfunction

    // First position at which sync is asserted.
    function automatic coord_t f_sync_start(input int active, input int fp);
        return coord_t'(active + fp);
    endfunction

    // First position after the sync pulse (exclusive end).
    function automatic coord_t f_sync_end(input int active, input int fp,
                                          input int sync);
        return coord_t'(active + fp + sync);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_timing_gen_sync_delay.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay
// Purpose  : Enable-qualified shift register used to retime the sync pair so
//            it lines up with the colorizer's registered RGB. DEPTH=0 is a
//            plain wire.
// Ports    : clk    - system clock
//            rst_n  - synchronous active-low reset (loads RST_VAL)
//            i_en   - stage advance enable (pixel-rate enable)
//            i_d    - data in
//            o_q    - data out, DEPTH enabled cycles behind i_d
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int               WIDTH   = 2,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Clock, reset and enable are intentionally unused here.
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, i_en};
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/display_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : display_timing_gen
// Purpose  : VGA raster timing generator. Produces scan coordinates, video_on,
//            horizontal/vertical sync (retimed by SYNC_DLY pixel-enable
//            stages) and line/frame start strobes.
// Ports    : clk          - system clock
//            rst_n        - synchronous active-low reset
//            pix_en       - pixel-rate enable; everything advances only on it
//            pixel_column - current column, 0..H_TOTAL-1
//            pixel_row    - current row, 0..V_TOTAL-1
//            video_on     - inside the visible area for the current coords
//            horiz_sync   - horizontal sync, SYNC_DLY enables late
//            vert_sync    - vertical sync, SYNC_DLY enables late
//            line_start   - high on the pix_en cycle whose edge wraps column
//            frame_start  - line_start that also wraps the row
// Revision : 1.0 - initial release
// ============================================================================
module display_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int SYNC_DLY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    output logic [c_COORD_W-1:0] pixel_column,
    output logic [c_COORD_W-1:0] pixel_row,
    output logic                 video_on,
    output logic                 horiz_sync,
    output logic                 vert_sync,
    output logic                 line_start,
    output logic                 frame_start
);

    localparam coord_t c_H_LAST   = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - coord_t'(1);
    localparam coord_t c_V_LAST   = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - coord_t'(1);
    localparam coord_t c_H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t c_V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t c_HS_START = f_sync_start(H_ACTIVE, H_FP);
    localparam coord_t c_HS_END   = f_sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam coord_t c_VS_START = f_sync_start(V_ACTIVE, V_FP);
    localparam coord_t c_VS_END   = f_sync_end(V_ACTIVE, V_FP, V_SYNC);
    localparam sync_t  c_SYNC_IDLE = '{hs: ~H_POL, vs: ~V_POL};

    coord_t r_h_cnt;
    coord_t r_v_cnt;
    logic   r_video_on;
    sync_t  r_sync;

    coord_t w_h_nxt;
    coord_t w_v_nxt;
    logic   w_h_wrap;
    logic   w_v_wrap;
    sync_t  w_sync_nxt;
    sync_t  w_sync_dly;

    assign w_h_wrap = (r_h_cnt == c_H_LAST);
    assign w_v_wrap = (r_v_cnt == c_V_LAST);

    // Next raster position; video_on and raw sync are derived from it so
    // that they are registered in step with the coordinates they describe.
    always_comb begin
        w_h_nxt = r_h_cnt + coord_t'(1);
        w_v_nxt = r_v_cnt;
        if (w_h_wrap) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_wrap ? '0 : (r_v_cnt + coord_t'(1));
        end
    end

    always_comb begin
        w_sync_nxt    = c_SYNC_IDLE;
        if ((w_h_nxt >= c_HS_START) && (w_h_nxt < c_HS_END)) begin
            w_sync_nxt.hs = H_POL;
        end
        if ((w_v_nxt >= c_VS_START) && (w_v_nxt < c_VS_END)) begin
            w_sync_nxt.vs = V_POL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_video_on <= 1'b0;
            r_sync     <= c_SYNC_IDLE;
        end else if (pix_en) begin
            r_h_cnt    <= w_h_nxt;
            r_v_cnt    <= w_v_nxt;
            r_video_on <= (w_h_nxt < c_H_VIS) && (w_v_nxt < c_V_VIS);
            r_sync     <= w_sync_nxt;
        end
    end

    // Retime sync so it meets the colorizer's registered RGB at the connector.
    sync_delay #(
        .WIDTH   (2),
        .DEPTH   (SYNC_DLY),
        .RST_VAL (c_SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (pix_en),
        .i_d   (r_sync),
        .o_q   (w_sync_dly)
    );

    assign pixel_column = r_h_cnt;
    assign pixel_row    = r_v_cnt;
    assign video_on     = r_video_on;
    assign horiz_sync   = w_sync_dly.hs;
    assign vert_sync    = w_sync_dly.vs;

    // Strobes mark the pix_en cycle whose edge performs the wrap. Gating with
    // rst_n keeps a reset landing on the last column from posing as a wrap.
    assign line_start  = rst_n & pix_en & w_h_wrap;
    assign frame_start = rst_n & pix_en & w_h_wrap & w_v_wrap;

endmodule
`default_nettype wire

// File: tb/tb_display_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_timing_gen
// Purpose  : Self-checking bench for display_timing_gen. A reduced raster
//            (16 x 8) keeps whole frames short. Three instances share the
//            stimulus: SYNC_DLY 1 (active-low), 3 (active-low), 0 (active-high).
//            The driver pushes the expected outputs for every cycle into a
//            queue; a monitor pops and compares. A second process measures
//            frame period, lines per frame and sync pulse widths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = 16;  // 8+2+3+3
    localparam int VT  = 8;   // 4+1+2+1
    localparam int FT  = 128; // HT*VT

    typedef struct packed {
        logic [11:0] col;
        logic [11:0] row;
        logic        von;
        logic        ls;
        logic        fs;
        logic        hs1;
        logic        vs1;
        logic        hs3;
        logic        vs3;
        logic        hs0;
        logic        vs0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [11:0] col1, row1, col3, row3, col0, row0;
    logic von1, hs1, vs1, ls1, fs1;
    logic von3, hs3, vs3, ls3, fs3;
    logic von0, hs0, vs0, ls0, fs0;

    always #5 clk = ~clk;

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(1)
    ) dut_d1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_column(col1), .pixel_row(row1), .video_on(von1),
        .horiz_sync(hs1), .vert_sync(vs1),
        .line_start(ls1), .frame_start(fs1)
    );

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b0), .V_POL(1'b0), .SYNC_DLY(3)
    ) dut_d3 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_column(col3), .pixel_row(row3), .video_on(von3),
        .horiz_sync(hs3), .vert_sync(vs3),
        .line_start(ls3), .frame_start(fs3)
    );

    display_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b1), .V_POL(1'b1), .SYNC_DLY(0)
    ) dut_d0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_column(col0), .pixel_row(row0), .video_on(von0),
        .horiz_sync(hs0), .vert_sync(vs0),
        .line_start(ls0), .frame_start(fs0)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   n_edges = 0;       // pix_en edges since the last reset edge
    bit   model_valid = 1'b0;

    // Measurement controls
    bit meas_on = 1'b0;
    bit width_on = 1'b0;
    int meas_period = 0;
    int n_periods = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sync level after cnt pix_en edges since reset, seen through dly stages.
    function automatic logic f_sync(input int cnt, input int dly, input bit horiz, input logic pol);
        int   m, c, r;
        logic in_win;
        if (cnt < dly) return ~pol;
        m = (cnt - dly) % FT;
        c = m % HT;
        r = m / HT;
        if (horiz) in_win = (c >= HA + HFP) && (c < HA + HFP + HS);
        else       in_win = (r >= VA + VFP) && (r < VA + VFP + VS);
        return in_win ? pol : ~pol;
    endfunction

    function automatic exp_t f_expect(input int cnt, input logic pe, input logic rn);
        exp_t e;
        int   p, c, r;
        p = cnt % FT;
        c = p % HT;
        r = p / HT;
        e.col = 12'(c);
        e.row = 12'(r);
        e.von = (cnt != 0) && (c < HA) && (r < VA);
        e.ls  = rn && pe && (c == HT - 1);
        e.fs  = e.ls && (r == VT - 1);
        e.hs1 = f_sync(cnt, 1, 1'b1, 1'b0);
        e.vs1 = f_sync(cnt, 1, 1'b0, 1'b0);
        e.hs3 = f_sync(cnt, 3, 1'b1, 1'b0);
        e.vs3 = f_sync(cnt, 3, 1'b0, 1'b0);
        e.hs0 = f_sync(cnt, 0, 1'b1, 1'b1);
        e.vs0 = f_sync(cnt, 0, 1'b0, 1'b1);
        return e;
    endfunction

    // One clock of stimulus; the expectation describes the DUT state seen
    // during this cycle (before the coming posedge).
    task automatic step(input logic rn, input logic pe);
        @(negedge clk);
        rst_n  = rn;
        pix_en = pe;
        if (model_valid) exp_q.push_back(f_expect(n_edges, pe, rn));
        if (!rn) begin
            n_edges     = 0;
            model_valid = 1'b1;
        end else if (pe) begin
            n_edges++;
        end
    endtask

    task automatic advance_to(input int pos);
        int guard = 0;
        while ((n_edges % FT) != pos && guard < 4 * FT) begin
            step(1'b1, 1'b1);
            guard++;
        end
        chk("advance_reached", 12'(n_edges % FT), 12'(pos));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("d1_col", col1, e.col);
            chk("d1_row", row1, e.row);
            chk("d1_video_on", {11'd0, von1}, {11'd0, e.von});
            chk("d1_line_start", {11'd0, ls1}, {11'd0, e.ls});
            chk("d1_frame_start", {11'd0, fs1}, {11'd0, e.fs});
            chk("d1_hsync", {11'd0, hs1}, {11'd0, e.hs1});
            chk("d1_vsync", {11'd0, vs1}, {11'd0, e.vs1});
            chk("d3_col", col3, e.col);
            chk("d3_row", row3, e.row);
            chk("d3_misc", {9'd0, von3, ls3, fs3}, {9'd0, e.von, e.ls, e.fs});
            chk("d3_hsync", {11'd0, hs3}, {11'd0, e.hs3});
            chk("d3_vsync", {11'd0, vs3}, {11'd0, e.vs3});
            chk("d0_col", col0, e.col);
            chk("d0_row", row0, e.row);
            chk("d0_misc", {9'd0, von0, ls0, fs0}, {9'd0, e.von, e.ls, e.fs});
            chk("d0_hsync", {11'd0, hs0}, {11'd0, e.hs0});
            chk("d0_vsync", {11'd0, vs0}, {11'd0, e.vs0});
        end
    end

    // Period / pulse-width measurement on the SYNC_DLY=1 instance.
    int cyc = 0, lines = 0, hs_run = 0, vs_run = 0;
    bit have_prev = 1'b0;
    always @(negedge clk) begin
        #3;
        if (meas_on) begin
            cyc++;
            if (ls1) lines++;
            if (fs1) begin
                if (have_prev) begin
                    chk("frame_period", 12'(cyc), 12'(meas_period));
                    chk("lines_per_frame", 12'(lines), 12'(VT));
                    n_periods++;
                end
                have_prev = 1'b1;
                cyc   = 0;
                lines = 0;
            end
        end else begin
            have_prev = 1'b0;
            cyc   = 0;
            lines = 0;
        end
        if (width_on) begin
            if (!hs1) hs_run++;
            else if (hs_run > 0) begin
                chk("hsync_width", 12'(hs_run), 12'(HS));
                hs_run = 0;
            end
            if (!vs1) vs_run++;
            else if (vs_run > 0) begin
                chk("vsync_width", 12'(vs_run), 12'(VS * HT));
                vs_run = 0;
            end
        end else begin
            hs_run = 0;
            vs_run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 5 clocks with pix_en high
        repeat (5) step(1'b0, 1'b1);

        // Free-running pixel enable: three frames
        meas_period = FT;
        meas_on     = 1'b1;
        width_on    = 1'b1;
        repeat (3 * FT) step(1'b1, 1'b1);
        meas_on  = 1'b0;
        width_on = 1'b0;
        step(1'b1, 1'b1);

        // One-in-four pixel enable
        meas_period = 4 * FT;
        meas_on     = 1'b1;
        for (int k = 0; k < 16 * FT; k++) step(1'b1, (k % 4) == 0);
        meas_on = 1'b0;
        step(1'b1, 1'b1);

        // Freeze just before hsync window, then release
        advance_to(HA + HFP - 1);
        repeat (100) step(1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1);

        // Mid-frame single-clock reset at column 5, row 2, then one frame+
        advance_to(2 * HT + 5);
        step(1'b0, 1'b1);
        repeat (FT + 10) step(1'b1, 1'b1);

        // Reset wins over a low pix_en, and on the last column of a line
        advance_to(HT - 1);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1);

        @(negedge clk);
        #5;
        chk("queue_drained", 12'(exp_q.size()), 12'd0);
        chk("periods_seen_ge4", {11'd0, (n_periods >= 4)}, 12'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
